muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with its sequencing FSM, owning the HI/LO register pair.
- Sits in the EX stage beside the ALU and is driven by decoded MD op codes from the control decoder.
- Models fixed mult/div latency with a busy countdown and raises a stall request toward the hazard logic while a D-stage instruction needs the unit.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; one clock; clears all state
- MDOp  input  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- D_use_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- Start  output  1  combinational: MDOp in 1..4 and not Busy
- Busy  output  1  registered; unit counting down
- MD_stall  output  1  combinational: D_use_md & (Start | Busy)
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset values: Busy=0, HI=0, LO=0, counter=0, pending result=0. Reset mid-operation aborts the op; HI/LO are cleared and never receive the aborted result.
- FSM has two states.
  - IDLE (Busy=0) is entered at reset.
  - In IDLE, if Start is high at cycle T:
    - latch pending {HI,LO} computed from A/B at T
    - load counter with N (MULT_CYCLES or DIV_CYCLES)
    - go to BUSY, so Busy=1 from T+1
  - BUSY (Busy=1): counter decrements each cycle. Busy stays high for exactly N cycles, T+1..T+N.
  - On the edge ending cycle T+N, the pending result is written to HI/LO and the FSM returns to IDLE. Busy=0 and the new HI/LO are visible at T+N+1.
- Arithmetic:
  - mult: signed 32x32 into a 64-bit product; HI=prod[63:32], LO=prod[31:0]
  - multu: same, unsigned
  - div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend
  - divu: unsigned quotient/remainder
  - div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0
- Divide by zero (B=0, div/divu): the full DIV_CYCLES busy period still runs; HI/LO are left unchanged at completion.
- mthi/mtlo (MDOp 5/6) with Busy=0: HI or LO takes A at the next edge. The other register is untouched. Busy does not assert.
- Any MDOp (1..6) arriving while Busy=1 is ignored: no restart and no HI/LO write. Upstream MD_stall normally prevents this; the unit stays robust anyway.
- Back-to-back: a Start at T+N+1 is accepted immediately and there is no dead cycle.
- HI/LO outputs are registers with no bypass. An mfhi/mflo consumer is held by MD_stall until Busy=0.
- MD_stall depends only on D_use_md, Start and Busy. It has no combinational path from A/B.
- MDOp=0 or 7 in IDLE: no state change.

Test Plan:
- Reset, then mult with A=0xFFFFFFFE (-2), B=3 -> Busy high exactly 5 cycles; at completion HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles. Then immediate div with A=-7 (0xFFFFFFF9), B=2 on the first idle cycle -> Busy for 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mthi A=0x12345678, then divu with A=5, B=0 -> Busy for 10 cycles; HI stays 0x12345678 and LO stays at its prior value.
- Start a div, drive D_use_md=1 throughout -> MD_stall=1 from the Start cycle through the last Busy cycle, 0 on the first idle cycle. A mtlo or mult injected while Busy has no effect.
- Assert reset at busy cycle 3 of a mult -> Busy=0, HI=LO=0 the next cycle; no late write follows.
- Signed overflow: div with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit for the EX stage. It owns the
// HI/LO register pair.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset; clears all state
//   MDOp[2:0]  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//              5 mthi, 6 mtlo, 7 reserved (no-op)
//   A, B       forwarded rs / rt operands
//   D_use_md   D-stage instruction needs the unit
//   Start      comb: a mult/div op is accepted this cycle
//   Busy       registered: a fixed-latency op is counting down
//   MD_stall   comb: D_use_md & (Start | Busy)
//   HI, LO     architectural HI/LO registers (no bypass)
//
// The result is computed in full when the op is accepted and is held in a
// pending register. The countdown only models latency. HI/LO change together
// on the last busy edge.
module muldiv_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_use_md,
  output logic        Start,
  output logic        Busy,
  output logic        MD_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] phi_q, plo_q;
  logic        pwr_q;          // pending result is written at completion

  logic        is_mul, is_div, is_sgn;
  logic [63:0] prod;
  logic [31:0] dvd, dvs, q_mag, r_mag;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  assign is_mul   = (MDOp == 3'd1) || (MDOp == 3'd2);
  assign is_div   = (MDOp == 3'd3) || (MDOp == 3'd4);
  assign is_sgn   = (MDOp == 3'd1) || (MDOp == 3'd3);
  assign Busy     = (state_q == S_BUSY);
  assign Start    = (is_mul || is_div) && !Busy;
  assign MD_stall = D_use_md && (Start || Busy);
  assign HI       = hi_q;
  assign LO       = lo_q;

  // One shared divider works on magnitudes. The signs are re-applied after
  // the divide. The quotient takes the XOR of the operand signs and the
  // remainder takes the sign of the dividend. For 0x80000000 / -1 the
  // magnitude quotient 0x80000000 is left as it is, which gives the
  // required wrap.
  always_comb begin
    prod   = '0;
    dvd    = A;
    dvs    = B;
    res_hi = hi_q;
    res_lo = lo_q;
    res_wr = 1'b0;
    if (is_mul) begin
      if (is_sgn) prod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
      else        prod = {32'd0, A} * {32'd0, B};
    end
    if (is_div && is_sgn) begin
      dvd = A[31] ? -A : A;
      dvs = B[31] ? -B : B;
    end
    if (dvs == 32'd0) dvs = 32'd1;   // keep the divider defined; result discarded
    q_mag = dvd / dvs;
    r_mag = dvd % dvs;
    if (is_mul) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
      res_wr = 1'b1;
    end else if (is_div) begin
      res_wr = (B != 32'd0);
      if (is_sgn) begin
        res_lo = (A[31] ^ B[31]) ? -q_mag : q_mag;
        res_hi = A[31] ? -r_mag : r_mag;
      end else begin
        res_lo = q_mag;
        res_hi = r_mag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      pwr_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            phi_q   <= res_hi;
            plo_q   <= res_lo;
            pwr_q   <= res_wr;
            cnt_q   <= is_mul ? MULT_N : DIV_N;
            state_q <= S_BUSY;
          end else if (MDOp == 3'd5) begin
            hi_q <= A;
          end else if (MDOp == 3'd6) begin
            lo_q <= A;
          end
        end
        S_BUSY: begin
          // All incoming MDOps are ignored until the countdown ends.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_IDLE;
            if (pwr_q) begin
              hi_q <= phi_q;
              lo_q <= plo_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        D_use_md;
  logic        Start, Busy, MD_stall;
  logic [31:0] HI, LO;

  muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .MDOp(MDOp), .A(A), .B(B), .D_use_md(D_use_md),
    .Start(Start), .Busy(Busy), .MD_stall(MD_stall), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_pwr;
  int          m_left;
  logic        last_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // The expected result is worked out with plain 64-bit arithmetic.
  task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic wr);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    hi = 0; lo = 0; wr = 1'b1;
    case (op)
      3'd1: begin p = longint'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      3'd2: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
      3'd3: if (b == 0) wr = 1'b0; else begin
              q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0];
            end
      3'd4: if (b == 0) wr = 1'b0; else begin
              p = ua / ub; hi = p[31:0]; p = ua % ub; lo = hi; hi = p[31:0]; lo = 32'(ua / ub);
            end
      default: wr = 1'b0;
    endcase
  endtask

  // Drive one cycle. The combinational outputs are checked before the edge
  // and the registered outputs after it. The model advances on the edge.
  task automatic step(input logic r, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic du);
    logic m_busy, m_start;
    logic [31:0] h, l;
    logic w;
    reset = r; MDOp = op; A = a; B = b; D_use_md = du;
    #1;
    m_busy  = (m_left > 0);
    m_start = (op >= 3'd1 && op <= 3'd4) && !m_busy;
    chk("Start", {31'd0, Start}, {31'd0, m_start});
    chk("MD_stall", {31'd0, MD_stall}, {31'd0, du && (m_start || m_busy)});
    last_stall = MD_stall;
    @(posedge clk);
    if (r) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0; m_left = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0 && m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (m_start) begin
      ref_op(op, a, b, h, l, w);
      m_phi = h; m_plo = l; m_pwr = w;
      m_left = (op <= 3'd2) ? MC : DC;
    end else if (op == 3'd5) m_hi = a;
    else if (op == 3'd6) m_lo = a;
    #1;
    chk("Busy", {31'd0, Busy}, {31'd0, m_left > 0});
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cnt;
    tbl[0] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
    tbl[1] = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MC};
    tbl[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    tbl[3] = '{3'd5, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFD, 0};
    tbl[4] = '{3'd4, 32'd5,        32'd0,        32'h12345678, 32'hFFFFFFFD, DC};
    tbl[5] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
    tbl[6] = '{3'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, DC};
    tbl[7] = '{3'd6, 32'hCAFEBABE, 32'd0,        32'h00000001, 32'hCAFEBABE, 0};
    tbl[8] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};
    tbl[9] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};

    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0; m_left = 0;
    reset = 1; MDOp = 0; A = 0; B = 0; D_use_md = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset_Busy", {31'd0, Busy}, 32'd0);
    chk("reset_HI", HI, 32'd0);
    chk("reset_LO", LO, 32'd0);

    // Each op goes in on the first idle cycle after the previous one ends.
    for (int i = 0; i < 10; i++) begin
      step(0, tbl[i].op, tbl[i].a, tbl[i].b, 0);
      cnt = 0;
      while (Busy === 1'b1 && cnt < 20) begin
        cnt++;
        step(0, 0, 0, 0, 0);
      end
      chk("tbl_cycles", 32'(cnt), 32'(tbl[i].cyc));
      chk("tbl_HI", HI, tbl[i].hi);
      chk("tbl_LO", LO, tbl[i].lo);
    end

    // Stall window with D_use_md held high. An mtlo and a mult are injected
    // while the unit is busy and must have no effect.
    step(0, 3'd3, 32'd100, 32'd7, 1);
    cnt = last_stall ? 1 : 0;
    for (int k = 0; k < 30 && Busy === 1'b1; k++) begin
      if (k == 2)      step(0, 3'd6, 32'hDEADBEEF, 0, 1);
      else if (k == 4) step(0, 3'd1, 32'd9, 32'd9, 1);
      else             step(0, 3'd0, 0, 0, 1);
      if (last_stall) cnt++;
    end
    chk("stall_cycles", 32'(cnt), 32'(DC + 1));
    step(0, 0, 0, 0, 1);
    chk("stall_idle", {31'd0, last_stall}, 32'd0);
    chk("inject_HI", HI, 32'd2);
    chk("inject_LO", LO, 32'd14);

    // Reset during busy cycle 3 of a mult aborts it. No late write follows.
    step(0, 3'd1, 32'd1000, 32'd1000, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("abort_Busy", {31'd0, Busy}, 32'd0);
    chk("abort_HI", HI, 32'd0);
    chk("abort_LO", LO, 32'd0);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 0);
    chk("abort_late_LO", LO, 32'd0);

    // Random traffic checked against the model.
    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 60) == 0), 3'($urandom_range(0, 7)),
           rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
